// File: rtl/store_buffer.sv
// Store buffer: formats SB/SH/SW requests into byte lanes, queues them in a
// DEPTH-entry FIFO and drains the head to data memory over a req/ack handshake.
module store_buffer #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         st_valid,
    output logic                         st_ready,
    input  logic [ADDR_W-1:0]            st_addr,
    input  logic [31:0]                  st_data,
    input  logic [2:0]                   st_funct3,
    output logic                         mem_req,
    input  logic                         mem_ack,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [31:0]                  mem_wdata,
    output logic [3:0]                   mem_be,
    output logic                         misalign,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic {S_IDLE = 1'b0, S_PRESENT = 1'b1} state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wdata;
        logic [3:0]        be;
    } entry_t;

    typedef struct packed {
        logic        ok;
        logic [3:0]  be;
        logic [31:0] wdata;
    } fmt_t;

    function automatic fmt_t format_store(input logic [2:0] funct3,
                                          input logic [1:0] a,
                                          input logic [31:0] d);
        fmt_t f;
        f.ok    = 1'b0;
        f.be    = 4'b0000;
        f.wdata = 32'h0000_0000;
        case (funct3)
            3'b000: begin
                f.ok    = 1'b1;
                f.be    = 4'b0001 << a;
                f.wdata = {4{d[7:0]}};
            end
            3'b001: begin
                f.ok    = ~a[0];
                f.be    = a[1] ? 4'b1100 : 4'b0011;
                f.wdata = {2{d[15:0]}};
            end
            3'b010: begin
                f.ok    = (a == 2'b00);
                f.be    = 4'b1111;
                f.wdata = d;
            end
            default: begin
                f.ok    = 1'b0;
                f.be    = 4'b0000;
                f.wdata = 32'h0000_0000;
            end
        endcase
        return f;
    endfunction

    entry_t               fifo_q [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_next_s;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 st_ready_q, empty_q, misalign_q;
    state_e               state_q;
    logic                 mem_req_q;
    entry_t               head_q, head_next_s, push_entry_s;
    fmt_t                 fmt_s;
    logic                 hs_s, push_s, pop_s;

    assign fmt_s        = format_store(st_funct3, st_addr[1:0], st_data);
    assign push_entry_s = '{addr: {st_addr[ADDR_W-1:2], 2'b00}, wdata: fmt_s.wdata, be: fmt_s.be};
    assign hs_s         = st_valid && st_ready_q;
    assign push_s       = hs_s && fmt_s.ok;
    assign pop_s        = (state_q == S_PRESENT) && mem_ack;
    assign rd_next_s    = rd_ptr_q + PTR_W'(1);

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_next_s;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Next head after a pop: the pushed entry bypasses storage when it is the only one left.
    always_comb begin
        head_next_s = push_entry_s;
        if (count_q > CNT_W'(1)) begin
            head_next_s = fifo_q[rd_next_s];
        end else begin
            head_next_s = push_entry_s;
        end
    end

    // FIFO storage write port.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_q[wr_ptr_q] <= push_entry_s;
        end
    end

    // Pointers, occupancy and registered status flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            st_ready_q <= 1'b1;
            empty_q    <= 1'b1;
            misalign_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            st_ready_q <= (count_d < DEPTH_C);
            empty_q    <= (count_d == '0);
            misalign_q <= hs_s && !fmt_s.ok;
        end
    end

    // Drain FSM with registered memory-side outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            mem_req_q <= 1'b0;
            head_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (count_q != '0) begin
                        state_q   <= S_PRESENT;
                        mem_req_q <= 1'b1;
                        head_q    <= fifo_q[rd_ptr_q];
                    end
                end
                S_PRESENT: begin
                    if (mem_ack) begin
                        if (count_d != '0) begin
                            head_q <= head_next_s;
                        end else begin
                            state_q   <= S_IDLE;
                            mem_req_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign st_ready  = st_ready_q;
    assign mem_req   = mem_req_q;
    assign mem_addr  = head_q.addr;
    assign mem_wdata = head_q.wdata;
    assign mem_be    = head_q.be;
    assign misalign  = misalign_q;
    assign empty     = empty_q;
    assign count     = count_q;

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: stimulus pushes expected memory writes,
// a negedge monitor pops and compares them as the DUT hands them to memory.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [2:0]  st_funct3;
    logic        mem_req;
    logic        mem_ack;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        misalign;
    logic        empty;
    logic [2:0]  count;

    always #5 clk = ~clk;

    store_buffer #(.ADDR_W(32), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .st_valid(st_valid), .st_ready(st_ready),
        .st_addr(st_addr), .st_data(st_data), .st_funct3(st_funct3),
        .mem_req(mem_req), .mem_ack(mem_ack), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .misalign(misalign),
        .empty(empty), .count(count)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } exp_t;

    exp_t exp_q[$];
    exp_t exp_cur;
    bit   exp_ok;
    int   checks = 0, errors = 0;
    int   exp_mis = 0, mis_seen = 0, req_cycles = 0, pops = 0;
    int   base_a, base_b;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compare memory handshakes against the queue, record accepted stores.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            if (misalign) mis_seen++;
            if (mem_req) req_cycles++;
            if (mem_req && mem_ack) begin
                pops++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: addr 0x%0h presented with nothing expected", mem_addr);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_addr", mem_addr, e.addr);
                    chk("sb_wdata", mem_wdata, e.wdata);
                    chk("sb_be", {28'd0, mem_be}, {28'd0, e.be});
                end
            end
            if (st_valid && st_ready) begin
                if (exp_ok) exp_q.push_back(exp_cur);
                else exp_mis++;
            end
        end
    end

    task automatic set_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                             input bit ok, input logic [31:0] ea, input logic [3:0] be,
                             input logic [31:0] wd);
        st_funct3 = f3;
        st_addr   = a;
        st_data   = d;
        exp_ok    = ok;
        exp_cur   = '{ea, wd, be};
        st_valid  = 1'b1;
    endtask

    task automatic wait_accept(input string name);
        bit hs;
        hs = 1'b0;
        for (int i = 0; i < 50 && !hs; i++) begin
            @(negedge clk);
            hs = st_valid && st_ready;
            @(posedge clk);
            #1;
        end
        if (!hs) begin
            checks++;
            errors++;
            $display("FAIL %s: store not accepted within 50 cycles", name);
        end
    endtask

    task automatic issue(input string name, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input bit ok, input logic [31:0] ea,
                         input logic [3:0] be, input logic [31:0] wd);
        set_store(f3, a, d, ok, ea, be, wd);
        wait_accept(name);
    endtask

    task automatic wait_drain(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            done = empty && !mem_req && (exp_q.size() == 0);
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s: not drained, queue %0d empty %0b", name, exp_q.size(), empty);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; st_valid = 1'b0; st_addr = 32'h0; st_data = 32'h0;
        st_funct3 = 3'b000; mem_ack = 1'b0; exp_ok = 1'b0;
        exp_cur = '{32'h0, 32'h0, 4'h0};
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        chk("rst_st_ready", {31'd0, st_ready}, 32'd1);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
        chk("rst_misalign", {31'd0, misalign}, 32'd0);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_count", {29'd0, count}, 32'd0);

        // 1: single SW, latency and drain
        mem_ack = 1'b1;
        issue("t1_sw", 3'b010, 32'h100, 32'hDEADBEEF, 1'b1, 32'h100, 4'hF, 32'hDEADBEEF);
        st_valid = 1'b0;
        chk("t1_req_early", {31'd0, mem_req}, 32'd0);
        @(posedge clk); #1;
        chk("t1_req", {31'd0, mem_req}, 32'd1);
        chk("t1_addr", mem_addr, 32'h100);
        chk("t1_be", {28'd0, mem_be}, 32'hF);
        chk("t1_wdata", mem_wdata, 32'hDEADBEEF);
        @(posedge clk); #1;
        chk("t1_empty", {31'd0, empty}, 32'd1);
        chk("t1_req_off", {31'd0, mem_req}, 32'd0);

        // 2: SB and SH lane formatting; gap makes SH push collide with SB pop
        issue("t2_sb", 3'b000, 32'h203, 32'h000000A5, 1'b1, 32'h200, 4'b1000, 32'hA5A5A5A5);
        st_valid = 1'b0;
        @(posedge clk); #1;
        issue("t2_sh", 3'b001, 32'h202, 32'h00001234, 1'b1, 32'h200, 4'b1100, 32'h12341234);
        st_valid = 1'b0;
        wait_drain("t2_drain");

        // 3: dropped stores
        base_a = mis_seen; base_b = req_cycles;
        issue("t3_sh", 3'b001, 32'h101, 32'h00005555, 1'b0, 32'h0, 4'h0, 32'h0);
        issue("t3_sw", 3'b010, 32'h102, 32'h66666666, 1'b0, 32'h0, 4'h0, 32'h0);
        issue("t3_f3", 3'b011, 32'h100, 32'h77777777, 1'b0, 32'h0, 4'h0, 32'h0);
        st_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t3_mis_pulses", mis_seen - base_a, 32'd3);
        chk("t3_mis_low", {31'd0, misalign}, 32'd0);
        chk("t3_count", {29'd0, count}, 32'd0);
        chk("t3_no_req", req_cycles - base_b, 32'd0);

        // 4: fill with memory stalled, then release
        mem_ack = 1'b0;
        for (int i = 0; i < 4; i++)
            issue("t4_fill", 3'b010, 32'h300 + 32'(4*i), 32'h11110000 + 32'(i), 1'b1,
                  32'h300 + 32'(4*i), 4'hF, 32'h11110000 + 32'(i));
        set_store(3'b010, 32'h310, 32'h55550005, 1'b1, 32'h310, 4'hF, 32'h55550005);
        repeat (2) @(posedge clk);
        #1;
        chk("t4_ready_full", {31'd0, st_ready}, 32'd0);
        chk("t4_count_full", {29'd0, count}, 32'd4);
        chk("t4_req", {31'd0, mem_req}, 32'd1);
        chk("t4_head", mem_addr, 32'h300);
        base_a = pops;
        mem_ack = 1'b1;
        wait_accept("t4_fifth");
        st_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("t4_back_to_back", pops - base_a, 32'd4);
        wait_drain("t4_drain");
        chk("t4_total", pops - base_a, 32'd5);

        // 5: full FIFO streaming with push+pop every cycle, wrapping pointers
        mem_ack = 1'b0;
        for (int i = 0; i < 4; i++)
            issue("t5_fill", 3'b010, 32'h600 + 32'(4*i), 32'hA0000000 + 32'(i), 1'b1,
                  32'h600 + 32'(4*i), 4'hF, 32'hA0000000 + 32'(i));
        mem_ack = 1'b1;
        for (int i = 4; i < 16; i++) begin
            issue("t5_stream", 3'b010, 32'h600 + 32'(4*i), 32'hA0000000 + 32'(i), 1'b1,
                  32'h600 + 32'(4*i), 4'hF, 32'hA0000000 + 32'(i));
            chk("t5_count_steady", {29'd0, count}, 32'd3);
        end
        st_valid = 1'b0;
        wait_drain("t5_drain");

        // 6: reset while presenting with three queued
        mem_ack = 1'b0;
        for (int i = 0; i < 3; i++)
            issue("t6_fill", 3'b010, 32'h400 + 32'(4*i), 32'hBB000000 + 32'(i), 1'b1,
                  32'h400 + 32'(4*i), 4'hF, 32'hBB000000 + 32'(i));
        st_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("t6_pre_req", {31'd0, mem_req}, 32'd1);
        chk("t6_pre_count", {29'd0, count}, 32'd3);
        reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        exp_q.delete();
        chk("t6_req", {31'd0, mem_req}, 32'd0);
        chk("t6_count", {29'd0, count}, 32'd0);
        chk("t6_empty", {31'd0, empty}, 32'd1);
        chk("t6_ready", {31'd0, st_ready}, 32'd1);
        mem_ack = 1'b1;
        base_b = req_cycles;
        repeat (5) @(posedge clk);
        #1;
        chk("t6_no_req", req_cycles - base_b, 32'd0);
        issue("t6_after", 3'b010, 32'h500, 32'hCAFEF00D, 1'b1, 32'h500, 4'hF, 32'hCAFEF00D);
        st_valid = 1'b0;
        wait_drain("t6_drain");

        chk("end_mis_total", mis_seen, exp_mis);
        chk("end_queue", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
